dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data port. It serves load/store requests
//  over a valid/ready request channel and a valid/ready response channel.
//  It holds a word-organised RAM, merges sub-word stores, and extracts plus
//  sign/zero-extends sub-word loads. Wait-state latency is programmable.
//  Sits behind the core's load/store path in place of the zero-latency dmem, so
//  that stall-capable core variants can be exercised.
// PARAMETERS
//  DEPTH_WORDS  1024          RAM size in 32-bit words; power of two.
//  LATENCY      1             wait cycles between accept and access, 0..15.
//  BASE_ADDR    32'h0000_0000 byte address of word 0; word-aligned.
// PORTS
//  clk        in   1   clock; all state updates on the rising edge.
//  rst        in   1   reset, synchronous, active-low.
//  req_valid  in   1   request present.
//  req_ready  out  1   responder can accept a request.
//  req_we     in   1   1 = store, 0 = load.
//  req_addr   in   32  byte address.
//  req_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0]).
//  req_funct3 in   3   RV32I width code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU (loads only).
//  rsp_valid  out  1   response present.
//  rsp_ready  in   1   requester accepts the response.
//  rsp_rdata  out  32  load result, extended; 0 for stores and errors.
//  rsp_err    out  1   request was misaligned, out of range or had an illegal funct3.
// BEHAVIOUR
//  - Reset (rst == 0 at an edge): state goes to IDLE, the wait counter is cleared, and the latched request is dropped.
//    Outputs while in reset: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
//    req_ready is registered and rises on the first edge with rst == 1. RAM contents are not reset.
//  - FSM states:
//    - IDLE: req_ready = 1. On req_valid && req_ready at edge N, latch we/addr/wdata/funct3 and drop req_ready.
//      Go to WAIT with count = LATENCY - 1, or go straight to RESP if LATENCY == 0.
//    - WAIT: decrement the counter. When the counter is 0, go to RESP.
//    - RESP: rsp_valid = 1. rsp_rdata and rsp_err are stable until rsp_valid && rsp_ready.
//      At that edge go to IDLE and set req_ready = 1 again.
//  - Access timing:
//    - The RAM access is performed on the edge that enters RESP.
//    - The store merge is committed at that edge. Load data is registered into rsp_rdata at that edge.
//    - rsp_valid is first high in cycle N + 1 + LATENCY.
//    - At most one request is outstanding. Peak throughput is 1 request per (LATENCY + 2) cycles.
//  - Error checks, evaluated on the latched request:
//    - misaligned: H/HU/SH with addr[0] != 0; W/SW with addr[1:0] != 0.
//    - out of range: (addr - BASE_ADDR) >= DEPTH_WORDS * 4, computed unsigned. Addresses below BASE wrap large, so they fault.
//    - illegal funct3: loads with 3/6/7; stores with any value >= 3.
//    - On error: no RAM write, rsp_err = 1, rsp_rdata = 0, same latency.
//  - Store byte-enables come from addr[1:0] and width: SB gives 1 << addr[1:0]; SH gives 4'b0011 << addr[1:0]; SW gives 4'b1111.
//    The data lanes are replicated (byte x4, half x2). Non-enabled bytes are unchanged.
//  - Load: select the word, shift right by 8 * addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU).
//  - Successful store: rsp_err = 0, rsp_rdata = 0.
//  - Inputs while req_ready = 0 are ignored; req_valid need not be held low.
//    rsp_ready while rsp_valid = 0 has no effect.
//  - Reset in WAIT or RESP: a pending store is not committed if reset hits before the RESP-entry edge.
//    A response that has not yet been taken is lost. No partial write ever occurs.
// STRUCTURE
//  - Shared package cpu_mem_pkg:
//    - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
//    - FSM state enum ST_IDLE/ST_WAIT/ST_RESP.
//    - WORD_W = 32.
//  - Sub-module dmem_lane_align (combinational): store path {funct3, addr[1:0], wdata} -> {be[3:0], lane_data}.
//    Load path {funct3, addr[1:0], word} -> extended result. Also flags misalignment. Reused later by the pipelined core's LSU.
//  - The top level holds the FSM, the wait counter, the request latch, the RAM array and the range check.
// TESTING
//  1. LATENCY=1: SW addr 0x10, data 0xDEADBEEF, then LW addr 0x10.
//     -> rdata = 0xDEADBEEF, err = 0, rsp_valid exactly 2 cycles after each accept.
//  2. SB addr 0x13, data 0x11 onto word 0xDEADBEEF.
//     -> LW = 0x11ADBEEF; LB 0x12 = 0xFFFFFFAD; LBU 0x12 = 0x000000AD; LHU 0x12 = 0x000011AD.
//  3. LH addr 0x11 -> err = 1, rdata = 0. SW addr 0x12 data 0 -> err = 1, and a later LW 0x10 still reads 0x11ADBEEF.
//  4. Backpressure: hold rsp_ready = 0 for 5 cycles while rsp_valid is high.
//     -> rdata/err stable, req_ready = 0, extra req_valid pulses are ignored. IDLE is reached one edge after rsp_ready rises.
//  5. LATENCY=4: SW addr 0x20 data 0x12345678, rst = 0 in the 2nd WAIT cycle, then release.
//     -> no rsp_valid is seen, and LW 0x20 returns the old contents.
//  6. LATENCY=0: LW to BASE + DEPTH_WORDS*4 -> err = 1.
//     Back-to-back loads with rsp_ready tied high are accepted every 2nd cycle.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared width codes, FSM states and helpers for the data-memory path
//
// Purpose: constants and types shared by the data-memory responder and the
// core's load/store path.
//   WORD_W             data word width
//   F3_B .. F3_HU      RV32I load/store width codes (funct3)
//   mem_state_e        responder FSM states
//   f3_illegal()       funct3 legality check for loads and stores
package cpu_mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Stores only know B/H/W; the unsigned variants exist for loads only.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3 >= 3'd3;
    end
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for sub-word stores and loads
//
// Purpose: combinational lane alignment between a byte address and a 32-bit
// memory word.
//   funct3_i      width code of the access
//   we_i          1 = store, 0 = load
//   addr_lo_i     byte offset within the word
//   wdata_i       right-aligned store data
//   rword_i       memory word read for a load
//   be_o          store byte enables
//   lane_data_o   store data replicated onto all lanes
//   rdata_o       load result, shifted down and extended
//   misaligned_o  access crosses its natural alignment
//   illegal_o     funct3 not valid for this direction
module dmem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic              we_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] rword_i,
  output logic [3:0]        be_o,
  output logic [WORD_W-1:0] lane_data_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              misaligned_o,
  output logic              illegal_o
);

  logic [WORD_W-1:0] shifted;

  // funct3[1:0] encodes the size for both signed and unsigned variants.
  assign misaligned_o = ((funct3_i[1:0] == 2'd1) && addr_lo_i[0]) ||
                        ((funct3_i[1:0] == 2'd2) && (addr_lo_i != 2'd0));
  assign illegal_o    = f3_illegal(we_i, funct3_i);

  always_comb begin
    be_o        = 4'b1111;
    lane_data_o = wdata_i;
    case (funct3_i[1:0])
      2'd0: begin
        be_o        = 4'b0001 << addr_lo_i;
        lane_data_o = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        be_o        = 4'b0011 << addr_lo_i;
        lane_data_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o        = 4'b1111;
        lane_data_o = wdata_i;
      end
    endcase
  end

  assign shifted = rword_i >> {addr_lo_i, 3'b000};

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_o = rword_i;
      F3_BU:   rdata_o = {24'd0, shifted[7:0]};
      F3_HU:   rdata_o = {16'd0, shifted[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder with sub-word merge
//
// Purpose: serves one load/store at a time from a word RAM with LATENCY wait
// cycles between accept and access.
//   clk, rst      clock; synchronous active-low reset
//   req_*         request channel (valid/ready, we, byte addr, wdata, funct3)
//   rsp_*         response channel (valid/ready, extended rdata, err)
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  mem_state_e        state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [2:0]        f3_q;

  logic              accept;
  logic              enter_resp;
  logic              from_inputs;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [2:0]        acc_f3;
  logic [31:0]       offset;
  logic              out_of_range;
  logic [AW-1:0]     word_idx;
  logic [3:0]        be;
  logic [WORD_W-1:0] lane_data;
  logic [WORD_W-1:0] load_data;
  logic              misaligned;
  logic              illegal;
  logic              err_d;
  logic [WORD_W-1:0] rdata_d;
  logic              mem_we;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign accept     = req_valid && req_ready_q;
  assign enter_resp = ((state_q == ST_IDLE) && accept && (LATENCY == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd0));

  // With zero latency the access happens on the accept edge itself, before
  // the latch holds the request, so the live inputs are used in IDLE.
  assign from_inputs = (state_q == ST_IDLE);
  assign acc_we      = from_inputs ? req_we     : we_q;
  assign acc_addr    = from_inputs ? req_addr   : addr_q;
  assign acc_wdata   = from_inputs ? req_wdata  : wdata_q;
  assign acc_f3      = from_inputs ? req_funct3 : f3_q;

  // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets.
  assign offset       = acc_addr - BASE_ADDR;
  assign out_of_range = {1'b0, offset} >= LIMIT;
  assign word_idx     = offset[AW+1:2];

  dmem_lane_align u_align (
    .funct3_i     (acc_f3),
    .we_i         (acc_we),
    .addr_lo_i    (acc_addr[1:0]),
    .wdata_i      (acc_wdata),
    .rword_i      (mem[word_idx]),
    .be_o         (be),
    .lane_data_o  (lane_data),
    .rdata_o      (load_data),
    .misaligned_o (misaligned),
    .illegal_o    (illegal)
  );

  assign err_d   = out_of_range || misaligned || illegal;
  assign rdata_d = (err_d || acc_we) ? '0 : load_data;
  assign mem_we  = rst && enter_resp && acc_we && !err_d;

  // RAM contents survive reset; the write only happens on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            f3_q        <= req_funct3;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= err_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at latencies 1, 4 and 0
module tb_dmem_responder;
  import cpu_mem_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst        [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic [2:0]  req_funct3 [N];
  logic        rsp_valid  [N];
  logic        rsp_ready  [N];
  logic [31:0] rsp_rdata  [N];
  logic        rsp_err    [N];

  // Instance 0: LATENCY 1, instance 1: LATENCY 4, instance 2: LATENCY 0 with BASE 0x1000.
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned LAT  = (g == 0) ? 1 : (g == 1) ? 4 : 0;
    localparam logic [31:0] BASE = (g == 2) ? 32'h0000_1000 : 32'h0000_0000;
    dmem_responder #(
      .DEPTH_WORDS (1024),
      .LATENCY     (LAT),
      .BASE_ADDR   (BASE)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_funct3 (req_funct3[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  typedef struct {
    int          inst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 0;
  endfunction

  function automatic vec_t mk(input int inst, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.inst = inst; v.we = we; v.addr = addr; v.wdata = wdata;
    v.f3 = f3; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i, input string tag, output logic ok);
    int n;
    n = 0;
    while (!req_ready[i] && n < 50) begin step(); n++; end
    ok = req_ready[i];
    if (!ok) check({tag, "_accept_timeout"}, 32'(req_ready[i]), 32'd1);
  endtask

  task automatic wait_rsp(input int i, input string tag, output logic ok);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < 50) begin step(); n++; end
    ok = rsp_valid[i];
    if (!ok) check({tag, "_rsp_timeout"}, 32'(rsp_valid[i]), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    req_we[v.inst]     = v.we;
    req_addr[v.inst]   = v.addr;
    req_wdata[v.inst]  = v.wdata;
    req_funct3[v.inst] = v.f3;
    req_valid[v.inst]  = 1'b1;
  endtask

  task automatic issue(input vec_t v, input string tag);
    int   i, t_acc;
    logic ok;
    exp_t e;
    i = v.inst;
    drive(v);
    wait_ready(i, tag, ok);
    if (!ok) begin req_valid[i] = 1'b0; return; end
    step();
    t_acc = cyc;
    req_valid[i] = 1'b0;
    e.rdata = v.rdata;
    e.err   = v.err;
    sb.push_back(e);
    wait_rsp(i, tag, ok);
    if (!ok) begin void'(sb.pop_front()); return; end
    check({tag, "_latency"}, 32'(cyc - t_acc), 32'(lat_of(i)));
    e = sb.pop_front();
    check({tag, "_rdata"}, rsp_rdata[i], e.rdata);
    check({tag, "_err"}, 32'(rsp_err[i]), 32'(e.err));
    step();
    check({tag, "_done"}, {30'd0, rsp_valid[i], req_ready[i]}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 400000)", $time);
    $fatal(1);
  end

  initial begin
    logic ok;
    exp_t e;
    int   acc, seen;
    vec_t v;

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_funct3[i] = F3_W; rsp_ready[i] = 1'b1;
    end
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_flags%0d", i), {29'd0, req_ready[i], rsp_valid[i], rsp_err[i]}, 32'd0);
      check($sformatf("reset_rdata%0d", i), rsp_rdata[i], 32'd0);
      rst[i] = 1'b1;
    end
    step();
    for (int i = 0; i < N; i++) check($sformatf("ready_after_reset%0d", i), 32'(req_ready[i]), 32'd1);

    // inst, we, addr, wdata, funct3, expected rdata, expected err
    vecs.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, F3_W,  32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h10, 32'h0,        F3_W,  32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 32'h13, 32'h11,       F3_B,  32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h10, 32'h0,        F3_W,  32'h11ADBEEF, 0));
    vecs.push_back(mk(0, 0, 32'h12, 32'h0,        F3_B,  32'hFFFFFFAD, 0));
    vecs.push_back(mk(0, 0, 32'h12, 32'h0,        F3_BU, 32'h000000AD, 0));
    vecs.push_back(mk(0, 0, 32'h12, 32'h0,        F3_HU, 32'h000011AD, 0));
    vecs.push_back(mk(0, 0, 32'h11, 32'h0,        F3_H,  32'h0,        1));
    vecs.push_back(mk(0, 1, 32'h12, 32'h0,        F3_W,  32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h10, 32'h0,        F3_W,  32'h11ADBEEF, 0));
    vecs.push_back(mk(0, 1, 32'h10, 32'hFFFF8001, F3_H,  32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h10, 32'h0,        F3_H,  32'hFFFF8001, 0));
    vecs.push_back(mk(0, 0, 32'h10, 32'h0,        F3_W,  32'h11AD8001, 0));
    vecs.push_back(mk(0, 0, 32'h10, 32'h0,        3'd3,  32'h0,        1));
    vecs.push_back(mk(0, 1, 32'h10, 32'h55,       3'd4,  32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h1000, 32'h0,      F3_W,  32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h10, 32'h0,        F3_W,  32'h11AD8001, 0));
    vecs.push_back(mk(1, 1, 32'h20, 32'hCAFEF00D, F3_W,  32'h0,        0));
    vecs.push_back(mk(1, 0, 32'h20, 32'h0,        F3_W,  32'hCAFEF00D, 0));
    vecs.push_back(mk(2, 1, 32'h1004, 32'hA5A5A5A5, F3_W, 32'h0,       0));
    vecs.push_back(mk(2, 0, 32'h2000, 32'h0,      F3_W,  32'h0,        1));
    vecs.push_back(mk(2, 0, 32'h0FFC, 32'h0,      F3_W,  32'h0,        1));
    vecs.push_back(mk(2, 0, 32'h1004, 32'h0,      F3_W,  32'hA5A5A5A5, 0));
    vecs.push_back(mk(2, 0, 32'h1007, 32'h0,      F3_B,  32'hFFFFFFA5, 0));
    for (int k = 0; k < vecs.size(); k++) issue(vecs[k], $sformatf("v%0d", k));

    // Backpressure on instance 0: response held for 5 cycles while stray requests arrive.
    rsp_ready[0] = 1'b0;
    drive(mk(0, 0, 32'h10, 32'h0, F3_W, 32'h0, 0));
    wait_ready(0, "bp", ok);
    if (ok) begin
      step();
      req_valid[0] = 1'b0;
      e.rdata = 32'h11AD8001; e.err = 1'b0;
      sb.push_back(e);
      wait_rsp(0, "bp", ok);
      for (int k = 0; k < 5; k++) begin
        req_valid[0] = k[0] ? 1'b0 : 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h0;
        check($sformatf("bp_flags%0d", k), {29'd0, rsp_valid[0], req_ready[0], rsp_err[0]}, 32'd4);
        check($sformatf("bp_rdata%0d", k), rsp_rdata[0], 32'h11AD8001);
        step();
      end
      req_valid[0] = 1'b0;
      e = sb.pop_front();
      check("bp_final_rdata", rsp_rdata[0], e.rdata);
      rsp_ready[0] = 1'b1;
      step();
      check("bp_idle", {30'd0, rsp_valid[0], req_ready[0]}, 32'd1);
      step(); step();
      check("bp_no_ghost", 32'(rsp_valid[0]), 32'd0);
    end
    issue(mk(0, 0, 32'h10, 32'h0, F3_W, 32'h11AD8001, 0), "bp_store_ignored");

    // Reset in the 2nd WAIT cycle of a LATENCY=4 store must drop it.
    drive(mk(1, 1, 32'h20, 32'h12345678, F3_W, 32'h0, 0));
    wait_ready(1, "rw", ok);
    if (ok) begin
      step();
      req_valid[1] = 1'b0;
      step();
      rst[1] = 1'b0;
      step();
      check("rw_reset_outs", {30'd0, rsp_valid[1], req_ready[1]}, 32'd0);
      rst[1] = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (rsp_valid[1]) seen++;
      end
      check("rw_no_rsp", 32'(seen), 32'd0);
      check("rw_ready", 32'(req_ready[1]), 32'd1);
    end
    issue(mk(1, 0, 32'h20, 32'h0, F3_W, 32'hCAFEF00D, 0), "rw_old_data");

    // Back-to-back loads at LATENCY=0 with rsp_ready high: one accept every 2nd cycle.
    v = mk(2, 0, 32'h1004, 32'h0, F3_W, 32'hA5A5A5A5, 0);
    drive(v);
    acc = 0;
    for (int s = 0; s < 12; s++) begin
      if (rsp_valid[2] && rsp_ready[2]) begin
        if (sb.size() == 0) check($sformatf("b2b_unexpected%0d", s), 32'(rsp_valid[2]), 32'd0);
        else begin
          e = sb.pop_front();
          check($sformatf("b2b_rdata%0d", s), rsp_rdata[2], e.rdata);
        end
      end
      if (req_valid[2] && req_ready[2]) begin
        acc++;
        e.rdata = v.rdata; e.err = v.err;
        sb.push_back(e);
      end
      step();
    end
    req_valid[2] = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd6);
    check("b2b_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
